// File: rtl/ex_pipe.sv
// Handshaked EX stage: ALU, branch resolution and an iterative MULT/MULTU unit with HI/LO.
// Define EX_PIPE_OVF_EN to register a signed-overflow flag for ADD/SUB/ADDI; otherwise ovf is tied low.
module ex_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Ins,
    input  logic [XLEN-1:0] nextPC,
    input  logic [XLEN-1:0] Rdata1,
    input  logic [XLEN-1:0] Rdata2,
    input  logic [XLEN-1:0] Ed32,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic [XLEN-1:0] newPC,
    output logic            taken,
    output logic            ovf,
    output logic            busy
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam int unsigned ZX_W = (XLEN < 16) ? XLEN : 16;
    localparam int unsigned MSB  = XLEN - 1;

    typedef enum logic {RUN, MUL} state_t;

    state_t state, state_next;

    logic [5:0]        op, funct;
    logic              accept, is_mul, load_alu, mul_done;
    logic [XLEN-1:0]   sum_rr, diff_rr, sum_ri, imm_zx;
    logic [XLEN-1:0]   alu_res, br_pc, pc_next;
    logic              br_taken;
    logic              unused_ins;

    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   hi, lo;
    logic [2*XLEN-1:0] acc, mcand, mul_step, product;
    logic [XLEN-1:0]   mplier, mul_pc;
    logic              neg;
    logic              mul_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;

    assign op         = Ins[31:26];
    assign funct      = Ins[5:0];
    assign unused_ins = ^Ins[25:6];

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (op == OP_RTYPE) && ((funct == F_MULT) || (funct == F_MULTU));
    assign load_alu = accept && !is_mul;
    assign mul_done = (state == MUL) && (count == CNT_W'(XLEN - 1));
    assign busy     = (state == MUL);

    assign sum_rr  = Rdata1 + Rdata2;
    assign diff_rr = Rdata1 - Rdata2;
    assign sum_ri  = Rdata1 + Ed32;

    always_comb begin
        imm_zx = '0;
        imm_zx[ZX_W-1:0] = Ed32[ZX_W-1:0];
    end

    always_comb begin
        alu_res  = '0;
        br_taken = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: alu_res = sum_rr;
                    F_SUB, F_SUBU: alu_res = diff_rr;
                    F_AND:  alu_res = Rdata1 & Rdata2;
                    F_OR:   alu_res = Rdata1 | Rdata2;
                    F_XOR:  alu_res = Rdata1 ^ Rdata2;
                    F_NOR:  alu_res = ~(Rdata1 | Rdata2);
                    F_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(Rdata1) < $signed(Rdata2))};
                    F_SLTU: alu_res = {{(XLEN-1){1'b0}}, (Rdata1 < Rdata2)};
                    F_MFHI: alu_res = hi;
                    F_MFLO: alu_res = lo;
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_res = sum_ri;
            OP_ANDI: alu_res = Rdata1 & imm_zx;
            OP_ORI:  alu_res = Rdata1 | imm_zx;
            OP_BEQ:  br_taken = (Rdata1 == Rdata2);
            OP_BNE:  br_taken = (Rdata1 != Rdata2);
            default: alu_res = '0;
        endcase
    end

    assign br_pc   = nextPC + (Ed32 << 2);
    assign pc_next = br_taken ? br_pc : nextPC;

    // Signed multiply runs on magnitudes; the sign is reapplied to the final product.
    assign mul_signed = (funct == F_MULT);
    assign a_neg      = mul_signed && Rdata1[MSB];
    assign b_neg      = mul_signed && Rdata2[MSB];
    assign a_mag      = a_neg ? (~Rdata1 + 1'b1) : Rdata1;
    assign b_mag      = b_neg ? (~Rdata2 + 1'b1) : Rdata2;

    assign mul_step = acc + (mplier[0] ? mcand : '0);
    assign product  = neg ? (~mul_step + 1'b1) : mul_step;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= RUN;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: if (accept && is_mul) state_next = MUL;
            MUL: if (mul_done)         state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            mul_pc <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (accept && is_mul) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= a_neg ^ b_neg;
            mul_pc <= nextPC;
        end else if (state == MUL) begin
            acc    <= mul_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (mul_done) begin
                count    <= '0;
                {hi, lo} <= product;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // mul_done and load_alu never coincide: in_ready is low throughout MUL.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid <= 1'b0;
            Result    <= '0;
            newPC     <= '0;
            taken     <= 1'b0;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            Result    <= '0;
            newPC     <= mul_pc;
            taken     <= 1'b0;
        end else if (load_alu) begin
            out_valid <= 1'b1;
            Result    <= alu_res;
            newPC     <= pc_next;
            taken     <= br_taken;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef EX_PIPE_OVF_EN
    logic ovf_next, ovf_q;

    always_comb begin
        ovf_next = 1'b0;
        if (op == OP_RTYPE && funct == F_ADD)
            ovf_next = (Rdata1[MSB] == Rdata2[MSB]) && (sum_rr[MSB] != Rdata1[MSB]);
        else if (op == OP_RTYPE && funct == F_SUB)
            ovf_next = (Rdata1[MSB] != Rdata2[MSB]) && (diff_rr[MSB] != Rdata1[MSB]);
        else if (op == OP_ADDI)
            ovf_next = (Rdata1[MSB] == Ed32[MSB]) && (sum_ri[MSB] != Rdata1[MSB]);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)          ovf_q <= 1'b0;
        else if (mul_done) ovf_q <= 1'b0;
        else if (load_alu) ovf_q <= ovf_next;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/ex_pipe.md
Name: ex_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle EX stage.
- Executes one decoded MIPS instruction per transaction and resolves BEQ/BNE branches into newPC.
- Adds an iterative MULT/MULTU unit with HI/LO registers. The stage stalls upstream while a multiply is in progress.
- Sits between ID (producer, valid/ready) and MEM (consumer, valid/ready).

Parameters:
- XLEN, 32, datapath width of Rdata1, Rdata2, Ed32, nextPC, newPC, Result, HI, LO (even, >=8).
- CNT_W, 6, width of the multiply cycle counter; must satisfy 2^CNT_W > XLEN.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- Ins  in  32  instruction word; op=Ins[31:26], funct=Ins[5:0].
- nextPC  in  XLEN  PC+4 of the instruction.
- Rdata1  in  XLEN  rs operand.
- Rdata2  in  XLEN  rt operand.
- Ed32  in  XLEN  sign-extended immediate.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  MEM accepts the result.
- Result  out  XLEN  ALU/address/HI/LO result.
- newPC  out  XLEN  next PC after branch resolution.
- taken  out  1  branch taken.
- ovf  out  1  signed overflow flag (see Optional Feature).
- busy  out  1  multiply in progress.

Behaviour:
- Reset (RST=0, async): out_valid=0, Result=0, newPC=0, taken=0, ovf=0, busy=0, HI=0, LO=0, state=RUN, counter=0. A reset asserted during a multiply aborts it and discards partial products.
- Handshake:
  - Accept when in_valid & in_ready.
  - in_ready = (state==RUN) & (!out_valid | out_ready).
  - The output register loads on accept. out_valid clears on out_ready & out_valid when no new accept occurs in the same cycle.
  - Simultaneous accept and drain in one cycle is allowed and yields back-to-back results.
  - Outputs stay stable while out_valid & !out_ready.
- Latency: single-cycle ops present out_valid on the edge after accept. Throughput is one per clock.
- Decode for op=0x00, by funct:
  - 0x20 ADD and 0x21 ADDU: Rdata1+Rdata2.
  - 0x22 SUB and 0x23 SUBU: Rdata1-Rdata2.
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
  - 0x2A SLT: signed compare, result 1/0.
  - 0x2B SLTU: unsigned compare, result 1/0.
  - 0x10 MFHI: Result=HI. 0x12 MFLO: Result=LO.
  - 0x18 MULT: signed. 0x19 MULTU: unsigned.
- Decode for other opcodes:
  - 0x08 ADDI and 0x09 ADDIU: Rdata1+Ed32.
  - 0x0C ANDI and 0x0D ORI: Ed32[15:0] zero-extended, then AND/OR with Rdata1.
  - 0x23 LW and 0x2B SW: Rdata1+Ed32.
  - 0x04 BEQ and 0x05 BNE: Result=0.
  - Any other op/funct: Result=0, taken=0, newPC=nextPC, out_valid still asserted.
- Arithmetic wraps modulo 2^XLEN.
- Branches:
  - taken = (Rdata1==Rdata2) for BEQ, (Rdata1!=Rdata2) for BNE.
  - newPC = nextPC + (Ed32<<2) if taken, else nextPC.
  - Non-branches: taken=0, newPC=nextPC.
- Multiply FSM (states RUN, MUL):
  - Accept of MULT/MULTU latches operands and enters MUL with counter=0.
  - busy=1 and in_ready=0 while in MUL.
  - One partial-product step per cycle; counter increments.
  - When counter reaches XLEN-1 the FSM writes the {HI,LO} 2*XLEN-bit product, sets out_valid with Result=0 and newPC=nextPC, and returns to RUN. out_valid rises XLEN edges after the accept edge.
  - MULT gives the signed product; MULTU the unsigned product.
  - HI/LO change only on multiply completion or reset.
  - An MFHI/MFLO accepted immediately after a multiply result reads the new HI/LO.
- A MUL-state entry is blocked if out_valid & !out_ready, by the in_ready rule above.

Optional Feature:
- Macro EX_PIPE_OVF_EN.
- Defined: ovf is registered with the result. ovf=1 for ADD, SUB, or ADDI with signed overflow; 0 for every other op, including ADDU/SUBU/ADDIU. Result still carries the wrapped sum.
- Undefined: ovf is constant 0 and no overflow logic is synthesised.

Test Plan:
1. BEQ, Ins={6'h04,26'd0}, Rdata1=Rdata2=10, nextPC=12, Ed32=24 -> taken=1, newPC=108. Repeat with Rdata2=300 -> taken=0, newPC=12.
2. Back-to-back ADD 5+7 then SUB 5-7 with out_ready=1 -> Result=12 then 0xFFFFFFFE on consecutive cycles, in_ready held 1.
3. Backpressure: out_ready=0 for 3 cycles after ADD result -> in_ready=0, Result held at 12. Next instruction accepted in the cycle out_ready returns to 1.
4. MULT Rdata1=0xFFFFFFFD, Rdata2=7 -> busy=1 and in_ready=0 for 32 cycles, out_valid 32 edges after accept. Then MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFEB. MULTU of the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
5. Reset pulse mid-MULT (cycle 10) -> busy=0, out_valid=0, HI=LO=0 immediately. Next MFLO returns 0.
6. With EX_PIPE_OVF_EN: ADD 0x7FFFFFFF+1 -> Result=0x80000000, ovf=1. ADDU same -> ovf=0. Without the macro -> ovf=0 for both.
